// File: rtl/operand_fetch.sv
// operand_fetch: single-entry operand-fetch stage between decode and execute.
// Reads both source registers, bypasses same-cycle writeback data, tracks
// in-flight destination registers in a pending-write scoreboard to stall
// RAW/WAW hazards, and counts hazard stall cycles.
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_rd_addr0,
  output logic [4:0]  rf_rd_addr1,
  input  logic [31:0] rf_rd_data0,
  input  logic [31:0] rf_rd_data1,
  input  logic        wb_ena,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [4:0]  out_rd,
  output logic        out_rd_wr,
  output logic [31:0] out_pc,
  output logic [31:0] stall_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] rs1_val_q, rs2_val_q, pc_q, stall_q;
  logic [4:0]  rd_q;
  logic        rd_wr_q;

  logic        clr1, clr2, clrd, hazard, accept;
  logic [31:0] op1, op2;

  assign rf_rd_addr0 = in_rs1;
  assign rf_rd_addr1 = in_rs2;

  assign out_valid   = (state_q == FULL);
  assign out_rs1_val = rs1_val_q;
  assign out_rs2_val = rs2_val_q;
  assign out_rd      = rd_q;
  assign out_rd_wr   = rd_wr_q;
  assign out_pc      = pc_q;
  assign stall_count = stall_q;

  // Hazard detection, handshake and operand selection with writeback bypass
  always_comb begin
    clr1   = wb_ena && (wb_addr == in_rs1);
    clr2   = wb_ena && (wb_addr == in_rs2);
    clrd   = wb_ena && (wb_addr == in_rd);
    hazard = ((in_rs1 != 5'd0) && pending_q[in_rs1] && !clr1) ||
             ((in_rs2 != 5'd0) && pending_q[in_rs2] && !clr2) ||
             (in_rd_wr && (in_rd != 5'd0) && pending_q[in_rd] && !clrd);
    in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
    accept   = in_valid && in_ready;

    if (in_rs1 == 5'd0) op1 = '0;
    else if (clr1)      op1 = wb_data;
    else                op1 = rf_rd_data0;

    if (in_rs2 == 5'd0) op2 = '0;
    else if (clr2)      op2 = wb_data;
    else                op2 = rf_rd_data1;
  end

  // Next entry state and scoreboard update; sets are applied last so they win
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;

    if (wb_ena && (wb_addr != 5'd0))
      pending_d[wb_addr] = 1'b0;
    if (flush && out_valid && rd_wr_q && (rd_q != 5'd0))
      pending_d[rd_q] = 1'b0;
    if (accept && in_rd_wr && (in_rd != 5'd0))
      pending_d[in_rd] = 1'b1;
    pending_d[0] = 1'b0;

    if (flush)                       state_d = EMPTY;
    else if (accept)                 state_d = FULL;
    else if (out_valid && out_ready) state_d = EMPTY;
  end

  // State, scoreboard and stall counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      pending_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (in_valid && hazard && !flush)
        stall_q <= stall_q + 32'd1;
    end
  end

  // Output entry payload, loaded only on accept so it holds under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      rd_q      <= '0;
      rd_wr_q   <= 1'b0;
      pc_q      <= '0;
    end else if (accept) begin
      rs1_val_q <= op1;
      rs2_val_q <= op2;
      rd_q      <= in_rd;
      rd_wr_q   <= in_rd_wr;
      pc_q      <= in_pc;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the stage.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_rd_wr, wb_ena, flush, out_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_addr;
  logic [31:0] in_pc, rf_rd_data0, rf_rd_data1, wb_data;
  logic        in_ready, out_valid, out_rd_wr;
  logic [4:0]  rf_rd_addr0, rf_rd_addr1, out_rd;
  logic [31:0] out_rs1_val, out_rs2_val, out_pc, stall_count;

  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
    .in_pc(in_pc), .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
    .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
    .wb_ena(wb_ena), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_wr(out_rd_wr), .out_pc(out_pc),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: set of registers with an outstanding producer, plus the
  // single held instruction record.
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_op1, m_op2, m_pc, m_stall;
  logic [4:0]  m_rd;
  bit          m_rdwr;

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // A register blocks issue if someone will write it and that write is not
  // landing this very cycle.
  function automatic bit blocked(input logic [4:0] r);
    return (r != 0) && m_pend[r] && !(wb_ena && wb_addr == r);
  endfunction

  function automatic bit m_hazard();
    return blocked(in_rs1) || blocked(in_rs2) || (in_rd_wr && blocked(in_rd));
  endfunction

  function automatic bit m_can_take();
    return !rst && !flush && !m_hazard() && (!m_valid || out_ready);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'd0;
    if (wb_ena && wb_addr == r) return wb_data;
    return rf;
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_valid = 0; m_op1 = 0; m_op2 = 0; m_pc = 0; m_stall = 0; m_rd = 0; m_rdwr = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({tag, ".stall"}, stall_count, m_stall);
    chk({tag, ".pend"}, dut.pending_q, pend_vec());
    if (m_valid) begin
      chk({tag, ".op1"}, out_rs1_val, m_op1);
      chk({tag, ".op2"}, out_rs2_val, m_op2);
      chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, m_rd});
      chk({tag, ".rdwr"}, {31'd0, out_rd_wr}, {31'd0, m_rdwr});
      chk({tag, ".pc"}, out_pc, m_pc);
    end
  endtask

  // One clock cycle; entered 1 time unit after a rising edge with inputs set.
  task automatic cycle(input string tag);
    bit acc, hz, clr_held;
    logic [4:0] held_rd;
    #2;
    chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, m_can_take()});
    chk({tag, ".addr"}, {22'd0, rf_rd_addr0, rf_rd_addr1}, {22'd0, in_rs1, in_rs2});
    acc = in_valid && m_can_take();
    hz  = m_hazard();
    clr_held = flush && m_valid && m_rdwr;
    held_rd  = m_rd;
    if (in_valid && hz && !flush) m_stall = m_stall + 1;
    if (wb_ena) m_pend[wb_addr] = 0;
    if (clr_held) m_pend[held_rd] = 0;
    if (acc && in_rd_wr) m_pend[in_rd] = 1;
    m_pend[0] = 0;
    if (acc) begin
      m_valid = 1;
      m_op1 = operand(in_rs1, rf_rd_data0);
      m_op2 = operand(in_rs2, rf_rd_data1);
      m_rd = in_rd; m_rdwr = in_rd_wr; m_pc = in_pc;
    end else if (flush || out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic issue(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic wr, input logic [31:0] pc);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rd_wr = wr; in_pc = pc;
  endtask

  initial begin
    rst = 1; flush = 0; out_ready = 0; wb_ena = 0; wb_addr = 0; wb_data = 0;
    rf_rd_data0 = 0; rf_rd_data1 = 0;
    issue(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", {31'd0, in_ready}, 32'd0);
    check_outputs("rst");
    chk("rst.op1", out_rs1_val, 32'd0);
    chk("rst.pc", out_pc, 32'd0);
    rst = 0;

    // No-hazard accept
    issue(1, 1, 2, 3, 1, 32'h100); rf_rd_data0 = 32'h11; rf_rd_data1 = 32'h22;
    cycle("A");
    chk("A.op1k", out_rs1_val, 32'h11);
    chk("A.op2k", out_rs2_val, 32'h22);
    chk("A.pendk", dut.pending_q, 32'h8);

    // RAW stall, then bypass when the producer writes back
    issue(1, 3, 0, 4, 1, 32'h104); out_ready = 1;
    cycle("B0");
    cycle("B1");
    chk("B.stallk", stall_count, 32'd2);
    wb_ena = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
    cycle("B2");
    chk("B.bypass", out_rs1_val, 32'hDEADBEEF);
    chk("B.pendk", dut.pending_q, 32'h10);

    // x0 rules: zero operand, no pending on rd=0, wb to x0 harmless
    issue(1, 0, 0, 0, 1, 32'h108); rf_rd_data0 = 32'hFFFFFFFF; wb_addr = 0;
    cycle("X0");
    chk("X0.op1k", out_rs1_val, 32'd0);
    chk("X0.pendk", dut.pending_q, 32'h10);
    wb_ena = 0;

    // Backpressure then same-cycle replace
    issue(1, 1, 0, 0, 0, 32'h10C); out_ready = 0;
    cycle("BP0");
    chk("BP.pc_hold", out_pc, 32'h108);
    out_ready = 1;
    cycle("BP1");
    chk("BP.replace", {31'd0, out_valid}, 32'd1);
    chk("BP.pck", out_pc, 32'h10C);

    // WAW with same-cycle writeback: set wins
    issue(1, 1, 2, 5, 1, 32'h110);
    cycle("W0");
    issue(1, 1, 2, 5, 1, 32'h114); wb_ena = 1; wb_addr = 5; wb_data = 32'h55;
    cycle("W1");
    chk("W.pend5", {31'd0, dut.pending_q[5]}, 32'd1);
    wb_ena = 0;

    // Flush drops held entry and its pending bit; incoming ignored
    issue(1, 1, 2, 6, 1, 32'h118); out_ready = 0; flush = 1;
    cycle("FL");
    chk("FL.validk", {31'd0, out_valid}, 32'd0);
    chk("FL.pend5", {31'd0, dut.pending_q[5]}, 32'd0);
    flush = 0;

    // Asynchronous reset in the middle of a stall
    issue(1, 1, 0, 9, 1, 32'h11C); out_ready = 1;
    cycle("E");
    issue(1, 9, 0, 0, 0, 32'h120);
    cycle("F");
    #2 rst = 1;
    #1;
    chk("arst.valid", {31'd0, out_valid}, 32'd0);
    chk("arst.ready", {31'd0, in_ready}, 32'd0);
    chk("arst.stall", stall_count, 32'd0);
    chk("arst.pend", dut.pending_q, 32'd0);
    chk("arst.out", out_rs1_val | out_rs2_val | out_pc | {27'd0, out_rd} | {31'd0, out_rd_wr}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      issue($urandom_range(99) < 70, 5'($urandom_range(7)), 5'($urandom_range(7)),
            5'($urandom_range(7)), $urandom_range(99) < 60, $urandom);
      rf_rd_data0 = $urandom; rf_rd_data1 = $urandom;
      wb_ena  = $urandom_range(99) < 40;
      wb_addr = 5'($urandom_range(7));
      wb_data = $urandom;
      flush   = $urandom_range(99) < 5;
      out_ready = $urandom_range(99) < 70;
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
